// File: rtl/akis_denetleyici.sv
// Command/frame sequencer between the UART RX FIFO, the hizlandirici accelerator and the UART TX FIFO.
// Parses a 2-byte host header, streams one frame through the accelerator and frames the response.
module akis_denetleyici #(
  parameter int unsigned FRAME_PIXELS = 76800,
  parameter int unsigned OUT_PIXELS   = 76800,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [7:0]  RESP_BYTE    = 8'h5A,
  parameter int unsigned TIMEOUT_CYC  = 10000000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [7:0]  s_veri_i,
  input  logic        s_gecerli_i,
  output logic        s_hazir_o,
  output logic [7:0]  h_veri_o,
  output logic        h_gecerli_o,
  input  logic        h_hazir_i,
  input  logic [7:0]  hz_veri_i,
  input  logic        hz_gecerli_i,
  output logic        hz_hazir_o,
  output logic [7:0]  m_veri_o,
  output logic        m_gecerli_o,
  input  logic        m_hazir_i,
  output logic        mesgul_o,
  output logic        hata_o,
  output logic [15:0] cerceve_sayisi_o
);

  localparam int unsigned IW = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned OW = $clog2(OUT_PIXELS + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    BOSTA, KOMUT, BASLIK0, BASLIK1, AKIS,
    DURUM0, DURUM1, DURUM2, DURUM3, HATA0, HATA1
  } durum_t;

  durum_t        r_durum, w_sonraki;
  logic [IW-1:0] r_in_cnt;
  logic [OW-1:0] r_out_cnt;
  logic [WW-1:0] r_wd;
  logic          r_hata;
  logic          r_mesgul;
  logic [15:0]   r_cerceve;
  logic [15:0]   r_snap;

  logic w_in_acik, w_out_acik, w_in_xfer, w_out_xfer, w_bitti, w_zaman;

  assign w_in_acik  = (r_in_cnt < IW'(FRAME_PIXELS));
  assign w_out_acik = (r_out_cnt < OW'(OUT_PIXELS));

  assign mesgul_o         = r_mesgul;
  assign hata_o           = r_hata;
  assign cerceve_sayisi_o = r_cerceve;

  always_comb begin
    w_sonraki   = r_durum;
    s_hazir_o   = 1'b0;
    h_veri_o    = '0;
    h_gecerli_o = 1'b0;
    hz_hazir_o  = 1'b0;
    m_veri_o    = '0;
    m_gecerli_o = 1'b0;
    w_in_xfer   = 1'b0;
    w_out_xfer  = 1'b0;
    w_bitti     = 1'b0;
    w_zaman     = 1'b0;
    case (r_durum)
      BOSTA: begin
        // Gated by reset so the FIFO read strobe is low while reset is held.
        s_hazir_o = rstn_i;
        if (s_gecerli_i && (s_veri_i == SYNC_BYTE)) w_sonraki = KOMUT;
      end
      KOMUT: begin
        s_hazir_o = 1'b1;
        if (s_gecerli_i) begin
          case (s_veri_i)
            8'h01:   w_sonraki = BASLIK0;
            8'h02:   w_sonraki = DURUM0;
            default: w_sonraki = HATA0;
          endcase
        end
      end
      BASLIK0: begin
        m_gecerli_o = 1'b1;
        m_veri_o    = RESP_BYTE;
        if (m_hazir_i) w_sonraki = BASLIK1;
      end
      BASLIK1: begin
        m_gecerli_o = 1'b1;
        m_veri_o    = 8'h01;
        if (m_hazir_i) w_sonraki = AKIS;
      end
      AKIS: begin
        h_veri_o    = s_veri_i;
        h_gecerli_o = s_gecerli_i && w_in_acik;
        s_hazir_o   = h_hazir_i && w_in_acik;
        m_veri_o    = hz_veri_i;
        m_gecerli_o = hz_gecerli_i && w_out_acik;
        hz_hazir_o  = m_hazir_i && w_out_acik;
        w_in_xfer   = h_gecerli_o && h_hazir_i;
        w_out_xfer  = m_gecerli_o && m_hazir_i;
        // Completion wins over the watchdog when both happen on the same cycle.
        w_bitti = (r_in_cnt == IW'(FRAME_PIXELS)) && (r_out_cnt == OW'(OUT_PIXELS));
        w_zaman = !w_bitti && !w_in_xfer && !w_out_xfer && (r_wd == WW'(TIMEOUT_CYC - 1));
        if (w_bitti || w_zaman) w_sonraki = BOSTA;
      end
      DURUM0: begin
        m_gecerli_o = 1'b1;
        m_veri_o    = RESP_BYTE;
        if (m_hazir_i) w_sonraki = DURUM1;
      end
      DURUM1: begin
        m_gecerli_o = 1'b1;
        m_veri_o    = 8'h02;
        if (m_hazir_i) w_sonraki = DURUM2;
      end
      DURUM2: begin
        m_gecerli_o = 1'b1;
        m_veri_o    = r_snap[15:8];
        if (m_hazir_i) w_sonraki = DURUM3;
      end
      DURUM3: begin
        m_gecerli_o = 1'b1;
        m_veri_o    = r_snap[7:0];
        if (m_hazir_i) w_sonraki = BOSTA;
      end
      HATA0: begin
        m_gecerli_o = 1'b1;
        m_veri_o    = RESP_BYTE;
        if (m_hazir_i) w_sonraki = HATA1;
      end
      HATA1: begin
        m_gecerli_o = 1'b1;
        m_veri_o    = 8'hEE;
        if (m_hazir_i) w_sonraki = BOSTA;
      end
      default: w_sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_durum   <= BOSTA;
      r_mesgul  <= 1'b0;
      r_hata    <= 1'b0;
      r_cerceve <= '0;
      r_snap    <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_wd      <= '0;
    end else begin
      r_durum  <= w_sonraki;
      r_mesgul <= (w_sonraki != BOSTA);
      if ((r_durum == KOMUT) && s_gecerli_i) begin
        if (s_veri_i == 8'h01)      r_hata <= 1'b0;
        else if (s_veri_i != 8'h02) r_hata <= 1'b1;
      end
      if ((r_durum == KOMUT) && (w_sonraki == DURUM0)) r_snap <= r_cerceve;
      if (r_durum == AKIS) begin
        if (w_bitti || w_zaman) begin
          r_in_cnt  <= '0;
          r_out_cnt <= '0;
          r_wd      <= '0;
          if (w_bitti) r_cerceve <= r_cerceve + 16'd1;
          else         r_hata    <= 1'b1;
        end else begin
          if (w_in_xfer)  r_in_cnt  <= r_in_cnt + IW'(1);
          if (w_out_xfer) r_out_cnt <= r_out_cnt + OW'(1);
          r_wd <= (w_in_xfer || w_out_xfer) ? '0 : r_wd + WW'(1);
        end
      end
    end
  end

endmodule

// File: doc/akis_denetleyici.md
Name: akis_denetleyici

Overview:
Command/frame sequencer between the UART RX FIFO, the hizlandirici accelerator and the UART TX FIFO. It parses a 2-byte host header and streams exactly one frame of pixels into the accelerator. It prefixes the accelerator output with a 2-byte response header and counts output bytes to close the frame. It also answers status queries, rejects unknown commands and recovers from a stalled accelerator with a watchdog.

Parameters:
FRAME_PIXELS  76800  bytes forwarded to the accelerator per frame (320*240)
OUT_PIXELS  76800  bytes expected from the accelerator per frame
SYNC_BYTE  8'hA5  host header start byte
RESP_BYTE  8'h5A  response header start byte
TIMEOUT_CYC  10000000  idle cycles in AKIS before abort

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
s_veri_i  in  8  byte from RX FIFO
s_gecerli_i  in  1  RX FIFO not empty
s_hazir_o  out  1  consume RX byte (drives FIFO rd_en)
h_veri_o  out  8  pixel to accelerator
h_gecerli_o  out  1  pixel valid
h_hazir_i  in  1  accelerator ready
hz_veri_i  in  8  accelerator output byte
hz_gecerli_i  in  1  accelerator output valid
hz_hazir_o  out  1  controller accepts accelerator byte
m_veri_o  out  8  byte to TX FIFO
m_gecerli_o  out  1  TX write enable
m_hazir_i  in  1  TX FIFO not full
mesgul_o  out  1  high in any state except BOSTA
hata_o  out  1  sticky error flag
cerceve_sayisi_o  out  16  completed frame count

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: all valid and ready outputs 0, m_veri_o/h_veri_o 0, hata_o 0, cerceve_sayisi_o 0, state BOSTA, all counters 0.
- Transfer rule: a byte moves on any port pair only in a cycle where valid && ready.
- BOSTA: s_hazir_o=1. Every byte is consumed. SYNC_BYTE -> KOMUT. Any other byte is discarded.
- KOMUT: s_hazir_o=1 and one byte is consumed.
  - 0x01 -> BASLIK0, and hata_o is cleared.
  - 0x02 -> DURUM.
  - Any other value -> HATA, and hata_o is set.
- BASLIK0/BASLIK1: s_hazir_o=0, hz_hazir_o=0. Emit RESP_BYTE, then 0x01, each held until m_hazir_i. BASLIK1 -> AKIS.
- AKIS: two independent pass-through paths, both combinational and with zero latency.
  - Input path: h_veri_o=s_veri_i; h_gecerli_o=s_gecerli_i && in_cnt<FRAME_PIXELS; s_hazir_o=h_hazir_i && in_cnt<FRAME_PIXELS.
  - Output path: m_veri_o=hz_veri_i; m_gecerli_o=hz_gecerli_i && out_cnt<OUT_PIXELS; hz_hazir_o=m_hazir_i && out_cnt<OUT_PIXELS.
  - in_cnt increments on each input transfer; out_cnt increments on each output transfer. Both paths may transfer in the same cycle.
  - Once in_cnt reaches FRAME_PIXELS, the next RX bytes stay in the FIFO (not consumed).
  - When in_cnt==FRAME_PIXELS and out_cnt==OUT_PIXELS: cerceve_sayisi_o increments (wraps 0xFFFF->0), counters clear, state -> BOSTA.
- Watchdog: a counter in AKIS clears on any transfer on either path, otherwise increments. On reaching TIMEOUT_CYC: set hata_o, clear counters, state -> BOSTA. The accelerator is not flushed; the host must reset.
- DURUM: emit 4 bytes, each held until m_hazir_i: RESP_BYTE, 0x02, cerceve_sayisi_o[15:8], cerceve_sayisi_o[7:0]. The count is snapshotted on entry. Then -> BOSTA.
- HATA: emit RESP_BYTE, then 0xEE. Then -> BOSTA.
- Outside AKIS: h_gecerli_o=0 and hz_hazir_o=0. Outside the emit states and AKIS: m_gecerli_o=0.
- mesgul_o is registered and equals (state!=BOSTA).
- Counter widths are $clog2(param+1).
- Reset mid-frame: everything returns to reset values immediately; the partial frame is not counted.

Test Plan:
- FRAME_PIXELS=OUT_PIXELS=16, loopback accelerator: send A5 01 + bytes 0x00..0x0F -> TX receives 5A 01 00..0F; cerceve_sayisi_o=1; mesgul_o returns to 0.
- Send 3 garbage bytes 11 22 33, then A5 02 -> all garbage consumed; TX receives 5A 02 00 01 (after one prior frame).
- Send A5 7F -> TX receives 5A EE; hata_o=1. A following A5 01 frame clears hata_o at KOMUT.
- During a frame, hold m_hazir_i=0 for 10 cycles at byte 5 -> no TX writes and no loss; TX order is intact and the frame completes with count+1.
- TIMEOUT_CYC=32, accelerator never asserts hz_gecerli_i -> after 32 idle cycles hata_o=1, state BOSTA, cerceve_sayisi_o unchanged.
- Assert rstn_i low at in_cnt=7 -> all outputs read 0 asynchronously (before the next edge). After release, a new full frame completes correctly.
